instr_encoder_loader: RTL

//  Inverse of the main decoder: accepts decoded instruction fields (class, regs, funct, imm) over a

---
 rtl/instr_encoder_loader.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Encodes decoded RV32I fields (LOAD/STORE/RTYPE/BRANCH/IALU/JAL) into words and writes them sequentially to imem.
// Latency: accept at edge N, encode at N+1, imem_we (or err_illegal) high in the cycle ending at edge N+2; one request per 3 cycles.
// Backpressure: in_ready only in IDLE and not full; a full buffer ignores requests until clear/reset.
module instr_encoder_loader #(
    parameter int          ADDR_W    = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    output logic              imem_we,
    output logic [31:0]       imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              err_illegal,
    output logic [ADDR_W:0]   count,
    output logic              full
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ENC   = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_ERR   = 2'd3;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_IALU   = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [ADDR_W:0] CAP = {1'b1, {ADDR_W{1'b0}}};

    logic [1:0]        state_q, state_d;
    logic [2:0]        cls_q, cls_d;
    logic [4:0]        rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
    logic [2:0]        f3_q, f3_d;
    logic              f7b5_q, f7b5_d;
    logic [31:0]       imm_q, imm_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [31:0]       addr_q, addr_d;
    logic [ADDR_W:0]   count_q, count_d;

    logic [31:0]       enc_word;
    logic              illegal;
    logic              imm12_ok, imm13_ok, imm21_ok, shamt_ok, is_shift;
    logic [ADDR_W-1:0] ptr;

    // The write pointer is the low bits of count; it is never used once count reaches capacity.
    assign ptr = count_q[ADDR_W-1:0];

    assign full        = (count_q == CAP);
    assign in_ready    = (state_q == S_IDLE) && !full;
    // Strobes are suppressed in the same cycle a clear/reset aborts the pending request.
    assign imem_we     = (state_q == S_WRITE) && !clear && !reset;
    assign err_illegal = (state_q == S_ERR) && !clear && !reset;
    assign imem_addr   = addr_q;
    assign imem_wdata  = wdata_q;
    assign count       = count_q;

    // Field-to-word encoding and immediate legality for the registered request.
    always_comb begin
        imm12_ok = (&imm_q[31:11]) | ~(|imm_q[31:11]);
        imm13_ok = ((&imm_q[31:12]) | ~(|imm_q[31:12])) & ~imm_q[0];
        imm21_ok = ((&imm_q[31:20]) | ~(|imm_q[31:20])) & ~imm_q[0];
        shamt_ok = ~(|imm_q[31:5]);
        is_shift = (f3_q == 3'b001) || (f3_q == 3'b101);
        enc_word = 32'h0;
        illegal  = 1'b1;
        case (cls_q)
            3'd0: begin
                enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_LOAD};
                illegal  = !imm12_ok;
            end
            3'd1: begin
                enc_word = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], OP_STORE};
                illegal  = !imm12_ok;
            end
            3'd2: begin
                enc_word = {1'b0, f7b5_q, 5'b0, rs2_q, rs1_q, f3_q, rd_q, OP_RTYPE};
                illegal  = 1'b0;
            end
            3'd3: begin
                enc_word = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q, imm_q[4:1], imm_q[11], OP_BRANCH};
                illegal  = !imm13_ok;
            end
            3'd4: begin
                if (is_shift) begin
                    enc_word = {1'b0, f7b5_q, 5'b0, imm_q[4:0], rs1_q, f3_q, rd_q, OP_IALU};
                    illegal  = !shamt_ok;
                end else begin
                    enc_word = {imm_q[11:0], rs1_q, f3_q, rd_q, OP_IALU};
                    illegal  = !imm12_ok;
                end
            end
            3'd5: begin
                enc_word = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, OP_JAL};
                illegal  = !imm21_ok;
            end
            default: begin
                enc_word = 32'h0;
                illegal  = 1'b1;
            end
        endcase
    end

    // FSM next state: capture on accept, latch the word in ENC, advance count when leaving WRITE.
    always_comb begin
        state_d = state_q;
        cls_d   = cls_q;
        rd_d    = rd_q;
        rs1_d   = rs1_q;
        rs2_d   = rs2_q;
        f3_d    = f3_q;
        f7b5_d  = f7b5_q;
        imm_d   = imm_q;
        wdata_d = wdata_q;
        addr_d  = addr_q;
        count_d = count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    cls_d   = in_class;
                    rd_d    = in_rd;
                    rs1_d   = in_rs1;
                    rs2_d   = in_rs2;
                    f3_d    = in_funct3;
                    f7b5_d  = in_funct7b5;
                    imm_d   = in_imm;
                    state_d = S_ENC;
                end
            end
            S_ENC: begin
                if (illegal) begin
                    state_d = S_ERR;
                end else begin
                    state_d = S_WRITE;
                    wdata_d = enc_word;
                    addr_d  = BASE_ADDR + 32'({ptr, 2'b00});
                end
            end
            S_WRITE: begin
                count_d = count_q + 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (clear) begin
            state_d = S_IDLE;
            count_d = '0;
            wdata_d = wdata_q;
            addr_d  = addr_q;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cls_q   <= 3'd0;
            rd_q    <= 5'd0;
            rs1_q   <= 5'd0;
            rs2_q   <= 5'd0;
            f3_q    <= 3'd0;
            f7b5_q  <= 1'b0;
            imm_q   <= 32'h0;
            wdata_q <= 32'h0;
            addr_q  <= BASE_ADDR;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            cls_q   <= cls_d;
            rd_q    <= rd_d;
            rs1_q   <= rs1_d;
            rs2_q   <= rs2_d;
            f3_q    <= f3_d;
            f7b5_q  <= f7b5_d;
            imm_q   <= imm_d;
            wdata_q <= wdata_d;
            addr_q  <= addr_d;
            count_q <= count_d;
        end
    end

endmodule
